// File: rtl/logic_exec_unit.sv
// Two-stage pipelined bitwise-logic execution unit: issue-side valid/ready in,
// CDB-side valid/ready out, with branch-recovery flush of in-flight ops.
module logic_exec_unit #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_ORN  = 3'b111
  } op_e;

  // Stage 1: latched issue fields
  logic             s1_v;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: latched result, drives the CDB outputs directly
  logic             s2_v;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] s1_result;

  assign s2_adv   = s1_v & (~s2_v | out_ready);
  assign in_ready = ~s1_v | s2_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_v & out_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_result = '0;
    unique case (s1_op)
      OP_AND:  s1_result =   s1_a & s1_b;
      OP_OR:   s1_result =   s1_a | s1_b;
      OP_XOR:  s1_result =   s1_a ^ s1_b;
      OP_NOR:  s1_result = ~(s1_a | s1_b);
      OP_NAND: s1_result = ~(s1_a & s1_b);
      OP_XNOR: s1_result = ~(s1_a ^ s1_b);
      OP_ANDN: s1_result =   s1_a & ~s1_b;
      OP_ORN:  s1_result =   s1_a | ~s1_b;
      default: s1_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v   <= 1'b0;
      s1_op  <= OP_AND;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
    end else begin
      if (in_fire) begin
        s1_op  <= op_e'(in_op);
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
      // A flush discards both the held op and any op handed over this cycle.
      if (flush)        s1_v <= 1'b0;
      else if (in_fire) s1_v <= 1'b1;
      else if (s2_adv)  s1_v <= 1'b0;
    end
  end

  // NOTE: the result/tag registers are reset (not just the valid bit) because
  // out_result, out_zero and out_tag must read zero while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v      <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (s2_adv) begin
        s2_result <= s1_result;
        s2_zero   <= ~|s1_result;
        s2_tag    <= s1_tag;
      end
      // A granted result replaced by a new one in the same cycle keeps s2_v set.
      if (flush)         s2_v <= 1'b0;
      else if (s2_adv)   s2_v <= 1'b1;
      else if (out_fire) s2_v <= 1'b0;
    end
  end

  assign out_valid  = s2_v;
  assign out_result = s2_result;
  assign out_zero   = s2_zero;
  assign out_tag    = s2_tag;

endmodule

// File: tb/tb_logic_exec_unit.sv
// Scoreboard bench for logic_exec_unit: accepted issues push expected results,
// an independent monitor pops and compares on every CDB transfer.
module tb_logic_exec_unit;

  localparam int WIDTH = 64;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  logic_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] cur_exp;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  bit               lat_check = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a | ~b;
    endcase
  endfunction

  // Issue tracker: a handshake in a flush cycle is discarded along with all in-flight ops.
  always @(negedge clk) begin
    if (!reset_n || flush) sb.delete();
    else if (in_valid && in_ready)
      sb.push_back('{res: cur_exp, zero: (cur_exp == '0), tag: in_tag, acc: cyc});
  end

  // Monitor: the CDB arbiter only counts a transfer when flush is low.
  bit               stall_prev = 1'b0;
  logic [WIDTH-1:0] prev_res;
  logic             prev_zero;
  logic [TAG_W-1:0] prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (stall_prev) begin
        check("stall_valid",  {63'd0, out_valid}, 64'd1);
        check("stall_result", out_result, prev_res);
        check("stall_zero",   {63'd0, out_zero}, {63'd0, prev_zero});
        check("stall_tag",    {58'd0, out_tag}, {58'd0, prev_tag});
      end
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got tag %0d result %h, expected no output", out_tag, out_result);
        end else begin
          e = sb.pop_front();
          check("out_tag",    {58'd0, out_tag}, {58'd0, e.tag});
          check("out_result", out_result, e.res);
          check("out_zero",   {63'd0, out_zero}, {63'd0, e.zero});
          if (lat_check) check("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      prev_res   = out_result;
      prev_zero  = out_zero;
      prev_tag   = out_tag;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [WIDTH-1:0] exp);
    bit done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; cur_exp = exp;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [WIDTH-1:0] A2 = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [WIDTH-1:0] B2 = 64'hFF00_FF00_FF00_FF00;
  logic [WIDTH-1:0] op_exp [8];

  initial begin
    op_exp[0] = 64'hF000_F000_F000_F000;
    op_exp[1] = 64'hFFF0_FFF0_FFF0_FFF0;
    op_exp[2] = 64'h0FF0_0FF0_0FF0_0FF0;
    op_exp[3] = 64'h000F_000F_000F_000F;
    op_exp[4] = 64'h0FFF_0FFF_0FFF_0FFF;
    op_exp[5] = 64'hF00F_F00F_F00F_F00F;
    op_exp[6] = 64'h00F0_00F0_00F0_00F0;
    op_exp[7] = 64'hF0FF_F0FF_F0FF_F0FF;

    // Reset held with a pending issue request
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_a = '1; in_b = '1; in_tag = 6'd9; cur_exp = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
      check("rst_out_result", out_result, 64'd0);
      check("rst_out_tag",    {58'd0, out_tag}, 64'd0);
      check("rst_out_zero",   {63'd0, out_zero}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // All eight opcodes back to back, latency checked
    lat_check = 1'b1;
    for (int i = 0; i < 8; i++) issue(3'(i), A2, B2, 6'(10 + i), op_exp[i]);
    drain();

    // Zero flag
    issue(3'd3, '1, '1, 6'd20, 64'd0);
    issue(3'd1, '0, '0, 6'd21, 64'd0);
    issue(3'd0, '1, 64'h8000_0000_0000_0000, 6'd22, 64'h8000_0000_0000_0000);
    drain();
    lat_check = 1'b0;

    // Backpressure: two ops fill the pipe, the third stalls
    out_ready = 1'b0;
    issue(3'd2, 64'h1234, 64'h00FF, 6'd1, 64'h12CB);
    issue(3'd6, 64'hFFFF, 64'h0F0F, 6'd2, 64'hF0F0);
    in_valid = 1'b1; in_op = 3'd7; in_a = '0; in_b = '1; in_tag = 6'd3; cur_exp = '0;
    @(negedge clk);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'd7, '0, '1, 6'd3, '0);
    drain();

    // Flush with two ops in flight and a same-cycle issue of tag 7
    out_ready = 1'b0;
    issue(3'd0, '1, '1, 6'd4, '1);
    issue(3'd1, '0, 64'h5, 6'd5, 64'h5);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd2; in_a = 64'hAA; in_b = 64'h55; in_tag = 6'd7; cur_exp = 64'hFF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready",  {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lat_check = 1'b1;
    issue(3'd5, 64'hF0, 64'h0F, 6'd8, 64'hFFFF_FFFF_FFFF_FF00);
    drain();
    lat_check = 1'b0;

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(1) != 0);
      flush     = ($urandom_range(15) == 0);
      in_op     = 3'($urandom_range(7));
      in_a      = {$urandom(), $urandom()};
      in_b      = ($urandom_range(7) == 0) ? in_a : {$urandom(), $urandom()};
      in_tag    = 6'(i);
      cur_exp   = model(in_op, in_a, in_b);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
